// File: rtl/tron_pkg.sv
// Shared definitions for the Tron game blocks: state codes, frame timing
// constants and the countdown seconds helper.
package tron_pkg;

    typedef enum logic [2:0] {
        GS_TITLE     = 3'd0,
        GS_COUNTDOWN = 3'd1,
        GS_PLAY      = 3'd2,
        GS_BLUE_WIN  = 3'd3,
        GS_RED_WIN   = 3'd4,
        GS_DRAW      = 3'd5,
        GS_PAUSED    = 3'd6
    } game_state_t;

    localparam int FRAMES_PER_SEC = 60;

    // Frame counter width; covers countdown and result-hold lengths up to 511.
    localparam int FRAME_CNT_W = 9;

    // Whole seconds left, rounded up and saturated to 3.
    function automatic logic [1:0] secs_remaining(input logic [FRAME_CNT_W-1:0] remaining);
        int r;
        r = int'(remaining);
        if (r > 2 * FRAMES_PER_SEC) begin
            return 2'd3;
        end else if (r > FRAMES_PER_SEC) begin
            return 2'd2;
        end else if (r > 0) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The detector only arms after it has seen the synchronized input low
// following reset, so a level held through reset release is not a press.
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       armed_q;
    logic       pulse_q;
    logic [1:0] fill_q;

    // Synchronize, remember the previous sample and emit a one-cycle pulse on a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value of
            // the one before it, which is what makes this a shift chain.
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // fill_q[1] marks that sync2_q now holds a real sample, not the reset value.
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
            pulse_q <= sync2_q & ~prev_q & armed_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game flow controller: title, countdown, play, pause and result
// screens, driven by frame strobes, key presses and score-block events.
module game_state_ctrl
    import tron_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int WIN_FRAMES       = 300
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic       Blue_W,
    input  logic       Red_W,
    input  logic       reset_round,
    output logic [2:0] Game_State,
    output logic       round_reset,
    output logic       freeze,
    output logic [1:0] countdown_sec
);

    localparam logic [FRAME_CNT_W-1:0] CD_TOTAL = FRAME_CNT_W'(COUNTDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] CD_LAST  = FRAME_CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] WIN_HOLD = FRAME_CNT_W'(WIN_FRAMES);

    logic frame_tick;
    logic start_press;
    logic pause_press;

    game_state_t            state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   round_reset_q, round_reset_d;
    logic                   freeze_q, freeze_d;
    logic [1:0]             countdown_sec_q, countdown_sec_d;

    edge_sync u_frame_sync (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .async_i (frame_clk),
        .pulse_o (frame_tick)
    );

    edge_sync u_start_sync (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .async_i (start_key),
        .pulse_o (start_press)
    );

    edge_sync u_pause_sync (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .async_i (pause_key),
        .pulse_o (pause_press)
    );

    // Next-state decision for the game flow.
    always_comb begin
        // NOTE: assigning the default first means every path drives state_d,
        // so no latch is inferred when a case arm leaves it unchanged.
        state_d = state_q;
        case (state_q)
            GS_TITLE: begin
                if (start_press) state_d = GS_COUNTDOWN;
            end
            GS_COUNTDOWN: begin
                if (frame_tick && (cnt_q == CD_LAST)) state_d = GS_PLAY;
            end
            GS_PLAY: begin
                // Win levels outrank a crash pulse; a crash outranks a pause press.
                if (Blue_W && Red_W)  state_d = GS_DRAW;
                else if (Blue_W)      state_d = GS_BLUE_WIN;
                else if (Red_W)       state_d = GS_RED_WIN;
                else if (reset_round) state_d = GS_COUNTDOWN;
                else if (pause_press) state_d = GS_PAUSED;
            end
            GS_BLUE_WIN, GS_RED_WIN, GS_DRAW: begin
                if (start_press && (cnt_q == WIN_HOLD)) state_d = GS_TITLE;
            end
            GS_PAUSED: begin
                if (pause_press) state_d = GS_PLAY;
            end
            default: state_d = GS_TITLE;
        endcase
    end

    // Frame counter next value: clear on any transition, count ticks in timed states.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            case (state_q)
                GS_COUNTDOWN: cnt_d = cnt_q + 1'b1;
                GS_BLUE_WIN, GS_RED_WIN, GS_DRAW: begin
                    if (cnt_q != WIN_HOLD) cnt_d = cnt_q + 1'b1;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Output values for the next cycle, derived from the upcoming state and count.
    always_comb begin
        round_reset_d   = (state_d == GS_COUNTDOWN) && (state_q != GS_COUNTDOWN);
        freeze_d        = (state_d != GS_PLAY);
        countdown_sec_d = (state_d == GS_COUNTDOWN) ? secs_remaining(CD_TOTAL - cnt_d) : 2'd0;
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= GS_TITLE;
        else       state_q <= state_d;
    end

    // Frame counter register.
    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            round_reset_q   <= 1'b0;
            freeze_q        <= 1'b1;
            countdown_sec_q <= 2'd0;
        end else begin
            round_reset_q   <= round_reset_d;
            freeze_q        <= freeze_d;
            countdown_sec_q <= countdown_sec_d;
        end
    end

    assign Game_State    = state_q;
    assign round_reset   = round_reset_q;
    assign freeze        = freeze_q;
    assign countdown_sec = countdown_sec_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl with a frame-level game model.
module tb_game_state_ctrl;

    localparam int CD  = 180;
    localparam int WIN = 300;
    localparam int FPS = 60;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       start_key;
    logic       pause_key;
    logic       Blue_W;
    logic       Red_W;
    logic       reset_round;
    logic [2:0] Game_State;
    logic       round_reset;
    logic       freeze;
    logic [1:0] countdown_sec;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state code and frames counted in the current state.
    int m_state  = 0;
    int m_frames = 0;

    game_state_ctrl #(.COUNTDOWN_FRAMES(CD), .WIN_FRAMES(WIN)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .start_key     (start_key),
        .pause_key     (pause_key),
        .Blue_W        (Blue_W),
        .Red_W         (Red_W),
        .reset_round   (reset_round),
        .Game_State    (Game_State),
        .round_reset   (round_reset),
        .freeze        (freeze),
        .countdown_sec (countdown_sec)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- model ----------------
    function automatic int exp_cd(input int st, input int fr);
        int s;
        if (st != 1) return 0;
        s = ((CD - fr) + FPS - 1) / FPS;
        return (s > 3) ? 3 : s;
    endfunction

    function automatic int play_next(input bit b, input bit r, input bit rr);
        if (b && r) return 5;
        if (b)      return 3;
        if (r)      return 4;
        if (rr)     return 1;
        return 2;
    endfunction

    task automatic model_tick();
        if (m_state == 1) begin
            m_frames++;
            if (m_frames == CD) begin
                m_state  = 2;
                m_frames = 0;
            end
        end else if (m_state >= 3 && m_state <= 5) begin
            if (m_frames < WIN) m_frames++;
        end
    endtask

    task automatic model_start();
        if (m_state == 0) begin
            m_state  = 1;
            m_frames = 0;
        end else if (m_state >= 3 && m_state <= 5 && m_frames >= WIN) begin
            m_state  = 0;
            m_frames = 0;
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_frames = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame strobe with random high/low widths; long enough to be fully absorbed.
    task automatic frame();
        int hi;
        int lo;
        hi = $urandom_range(1, 3);
        lo = $urandom_range(4, 6);
        frame_clk = 1'b1;
        step(hi);
        frame_clk = 1'b0;
        step(lo);
        model_tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // From TITLE: press start, release, and run the full countdown.
    task automatic enter_play();
        start_key = 1'b1;
        step(4);
        model_start();
        start_key = 1'b0;
        step(6);
        frames(CD);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        step(3);
        n_checks++; if (Game_State !== 3'd0) begin n_errors++; $display("FAIL rst_state: got %0d expected 0", Game_State); end
        n_checks++; if (round_reset !== 1'b0) begin n_errors++; $display("FAIL rst_round_reset: got %b expected 0", round_reset); end
        n_checks++; if (freeze !== 1'b1) begin n_errors++; $display("FAIL rst_freeze: got %b expected 1", freeze); end
        n_checks++; if (countdown_sec !== 2'd0) begin n_errors++; $display("FAIL rst_cd_sec: got %0d expected 0", countdown_sec); end
        Reset = 1'b0;
        model_reset();
        step(6);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL idle_state: got %0d expected %0d", Game_State, m_state); end
    endtask

    task automatic test_start_countdown();
        start_key = 1'b1;
        step(3);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL start_latency: got %0d expected %0d", Game_State, m_state); end
        step(1);
        model_start();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL start_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (round_reset !== 1'b1) begin n_errors++; $display("FAIL start_round_reset: got %b expected 1", round_reset); end
        n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL start_cd_sec: got %0d expected %0d", countdown_sec, exp_cd(m_state, m_frames)); end
        n_checks++; if (freeze !== 1'b1) begin n_errors++; $display("FAIL start_freeze: got %b expected 1", freeze); end
        step(1);
        n_checks++; if (round_reset !== 1'b0) begin n_errors++; $display("FAIL start_round_reset_width: got %b expected 0", round_reset); end
        start_key = 1'b0;
        step(5);
        for (int i = 0; i < CD; i++) begin
            frame();
            n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL cd_state tick %0d: got %0d expected %0d", i + 1, Game_State, m_state); end
            n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL cd_sec tick %0d: got %0d expected %0d", i + 1, countdown_sec, exp_cd(m_state, m_frames)); end
        end
        n_checks++; if (Game_State !== 3'd2) begin n_errors++; $display("FAIL play_state: got %0d expected 2", Game_State); end
        n_checks++; if (freeze !== 1'b0) begin n_errors++; $display("FAIL play_freeze: got %b expected 0", freeze); end
    endtask

    task automatic test_reset_round();
        int n;
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        m_state  = play_next(1'b0, 1'b0, 1'b1);
        m_frames = 0;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL crash_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (round_reset !== 1'b1) begin n_errors++; $display("FAIL crash_round_reset: got %b expected 1", round_reset); end
        n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL crash_cd_sec: got %0d expected %0d", countdown_sec, exp_cd(m_state, m_frames)); end
        step(1);
        n_checks++; if (round_reset !== 1'b0) begin n_errors++; $display("FAIL crash_round_reset_width: got %b expected 0", round_reset); end
        n = $urandom_range(61, 120);
        frames(n);
        n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL crash_cd_mid: got %0d expected %0d", countdown_sec, exp_cd(m_state, m_frames)); end
        frames(CD - n);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL crash_replay: got %0d expected %0d", Game_State, m_state); end
    endtask

    task automatic test_win_priority();
        Blue_W      = 1'b1;
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        Blue_W      = 1'b0;
        m_state  = play_next(1'b1, 1'b0, 1'b1);
        m_frames = 0;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL prio_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (round_reset !== 1'b0) begin n_errors++; $display("FAIL prio_round_reset: got %b expected 0", round_reset); end
        n_checks++; if (freeze !== 1'b1) begin n_errors++; $display("FAIL prio_freeze: got %b expected 1", freeze); end
        start_key = 1'b1;
        step(4);
        model_start();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL prio_early_start: got %0d expected %0d", Game_State, m_state); end
        start_key = 1'b0;
        Reset = 1'b1;
        step(1);
        model_reset();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL win_reset: got %0d expected %0d", Game_State, m_state); end
        Reset = 1'b0;
        step(6);
    endtask

    task automatic test_draw();
        enter_play();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL draw_play: got %0d expected %0d", Game_State, m_state); end
        Blue_W = 1'b1;
        Red_W  = 1'b1;
        step(1);
        m_state  = play_next(1'b1, 1'b1, 1'b0);
        m_frames = 0;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL draw_state: got %0d expected %0d", Game_State, m_state); end
        Blue_W = 1'b0;
        Red_W  = 1'b0;
        frames(100);
        start_key = 1'b1;
        step(4);
        model_start();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL draw_start_f100: got %0d expected %0d", Game_State, m_state); end
        start_key = 1'b0;
        step(6);
        frames(201);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL draw_hold: got %0d expected %0d", Game_State, m_state); end
        start_key = 1'b1;
        step(4);
        model_start();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL draw_start_f301: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (freeze !== 1'b1) begin n_errors++; $display("FAIL title_freeze: got %b expected 1", freeze); end
        start_key = 1'b0;
        step(6);
    endtask

    task automatic test_pause();
        enter_play();
        pause_key = 1'b1;
        step(4);
        m_state = 6;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL pause_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (freeze !== 1'b1) begin n_errors++; $display("FAIL pause_freeze: got %b expected 1", freeze); end
        step(10);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL pause_held: got %0d expected %0d", Game_State, m_state); end
        pause_key = 1'b0;
        step(6);
        Red_W = 1'b1;
        step(3);
        reset_round = 1'b1;
        step(1);
        reset_round = 1'b0;
        frame();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL pause_ignore: got %0d expected %0d", Game_State, m_state); end
        pause_key = 1'b1;
        step(4);
        m_state = 2;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL unpause_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (freeze !== 1'b0) begin n_errors++; $display("FAIL unpause_freeze: got %b expected 0", freeze); end
        step(1);
        m_state = play_next(1'b0, 1'b1, 1'b0);
        m_frames = 0;
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL unpause_red: got %0d expected %0d", Game_State, m_state); end
        Red_W     = 1'b0;
        pause_key = 1'b0;
        step(6);
    endtask

    task automatic test_key_held_reset();
        Reset     = 1'b1;
        start_key = 1'b1;
        step(3);
        model_reset();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL held_rst_state: got %0d expected %0d", Game_State, m_state); end
        Reset = 1'b0;
        step(12);
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL held_key_no_press: got %0d expected %0d", Game_State, m_state); end
        start_key = 1'b0;
        step(6);
        start_key = 1'b1;
        step(4);
        model_start();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL held_repress: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (round_reset !== 1'b1) begin n_errors++; $display("FAIL held_round_reset: got %b expected 1", round_reset); end
        start_key = 1'b0;
        step(6);
    endtask

    task automatic test_reset_mid_countdown();
        frames(90);
        n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL f90_cd_sec: got %0d expected %0d", countdown_sec, exp_cd(m_state, m_frames)); end
        Reset = 1'b1;
        step(1);
        model_reset();
        n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL f90_rst_state: got %0d expected %0d", Game_State, m_state); end
        n_checks++; if (countdown_sec !== 2'd0) begin n_errors++; $display("FAIL f90_rst_cd_sec: got %0d expected 0", countdown_sec); end
        Reset = 1'b0;
        step(6);
        start_key = 1'b1;
        step(4);
        model_start();
        n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL f90_restart_cd: got %0d expected %0d", countdown_sec, exp_cd(m_state, m_frames)); end
        start_key = 1'b0;
        step(6);
    endtask

    // Random play-time events, then random hold lengths before a start press.
    task automatic test_random_rounds();
        for (int it = 0; it < 4; it++) begin
            bit b;
            bit r;
            bit rr;
            int k;
            Reset = 1'b1;
            step(1);
            Reset = 1'b0;
            model_reset();
            step(6);
            enter_play();
            b  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            Blue_W = b;
            Red_W = r;
            reset_round = rr;
            step(1);
            Blue_W = 1'b0;
            Red_W = 1'b0;
            reset_round = 1'b0;
            m_state  = play_next(b, r, rr);
            m_frames = 0;
            n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL rnd_event %0d: got %0d expected %0d", it, Game_State, m_state); end
            n_checks++; if (round_reset !== (m_state == 1)) begin n_errors++; $display("FAIL rnd_round_reset %0d: got %b expected %b", it, round_reset, m_state == 1); end
            if (m_state == 1) begin
                k = $urandom_range(1, CD - 1);
                frames(k);
                n_checks++; if (countdown_sec !== 2'(exp_cd(m_state, m_frames))) begin n_errors++; $display("FAIL rnd_cd %0d: got %0d expected %0d", it, countdown_sec, exp_cd(m_state, m_frames)); end
            end else if (m_state != 2) begin
                k = $urandom_range(250, 340);
                frames(k);
                start_key = 1'b1;
                step(4);
                model_start();
                n_checks++; if (Game_State !== 3'(m_state)) begin n_errors++; $display("FAIL rnd_hold %0d frames %0d: got %0d expected %0d", it, k, Game_State, m_state); end
                start_key = 1'b0;
                step(6);
            end
        end
    endtask

    initial begin
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        start_key   = 1'b0;
        pause_key   = 1'b0;
        Blue_W      = 1'b0;
        Red_W       = 1'b0;
        reset_round = 1'b0;
        test_reset();
        test_start_countdown();
        test_reset_round();
        test_win_priority();
        test_draw();
        test_pause();
        test_key_held_reset();
        test_reset_mid_countdown();
        test_random_rounds();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter COUNTDOWN_FRAMES, default 180: frames spent in COUNTDOWN before PLAY (3 s at 60 Hz).
REQ-002 Parameter WIN_FRAMES, default 300: minimum frames a result screen is held before start_key is honoured.
REQ-003 Clk  input  1  50 MHz system clock; single clock domain.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_clk  input  1  ~60 Hz frame strobe from the VGA controller; asynchronous to Clk.
REQ-006 start_key  input  1  level, high while the start key (Enter) is held.
REQ-007 pause_key  input  1  level, high while the pause key (P) is held.
REQ-008 Blue_W, Red_W  input  1 each  win levels from the score block.
REQ-009 reset_round  input  1  one-cycle crash pulse from the score block.
REQ-010 Game_State  output  3  current state code, consumed by the score, bike and render blocks.
REQ-011 round_reset  output  1  one-cycle pulse; bikes return to start positions and the trail RAM clears.
REQ-012 freeze  output  1  high when bikes must not move.
REQ-013 countdown_sec  output  2  seconds remaining in COUNTDOWN (3..1); 0 in all other states.

Function
REQ-014 State codes SHALL be: TITLE=0, COUNTDOWN=1, PLAY=2, BLUE_WIN=3, RED_WIN=4, DRAW=5, PAUSED=6.
REQ-015 frame_clk SHALL pass through a 2-flop synchronizer and a rising-edge detector to form frame_tick, one Clk cycle wide, 3-cycle latency.
REQ-016 start_key and pause_key SHALL each be edge-detected; only a 0->1 transition counts as a press, and a held key never re-triggers.
REQ-017 TITLE -> COUNTDOWN on a start press, with a round_reset pulse in the same cycle as the transition.
REQ-018 COUNTDOWN SHALL count frame_tick; after COUNTDOWN_FRAMES ticks -> PLAY.
REQ-019 countdown_sec SHALL equal ceil(remaining_frames/60), saturated to 3.
REQ-020 In PLAY, Blue_W=1 and Red_W=1 in the same cycle -> DRAW.
REQ-021 In PLAY, Blue_W=1 alone -> BLUE_WIN; Red_W=1 alone -> RED_WIN.
REQ-022 In PLAY with no win level, a reset_round pulse -> COUNTDOWN, with a round_reset pulse on the transition.
REQ-023 Win levels SHALL take priority over reset_round when both are present in the same cycle.
REQ-024 PLAY -> PAUSED on a pause press; PAUSED -> PLAY on the next pause press; no other exit from PAUSED except Reset.
REQ-025 Win levels and reset_round arriving while PAUSED SHALL be ignored.
REQ-026 In BLUE_WIN, RED_WIN and DRAW, the frame counter SHALL count to WIN_FRAMES and then saturate.
REQ-027 From BLUE_WIN, RED_WIN or DRAW: a start press after saturation -> TITLE; a start press before saturation is ignored.
REQ-028 The frame counter SHALL clear on every state transition; it is 9 bits wide, sized for max(COUNTDOWN_FRAMES, WIN_FRAMES) <= 511.
REQ-029 freeze SHALL be 1 in every state except PLAY.
REQ-030 All outputs SHALL be registered; Game_State changes exactly one cycle after the qualifying event is sampled.
REQ-031 round_reset SHALL never assert for two consecutive cycles.

Reset
REQ-032 While Reset=1: Game_State=TITLE, round_reset=0, freeze=1, countdown_sec=0, frame counter=0, synchronizer and edge-detect flops=0.
REQ-033 A key held through Reset release SHALL NOT generate a press.
REQ-034 Reset asserted in any state SHALL return the block to TITLE on the next clock, discarding any countdown or win hold in progress.

Structure
REQ-035 The game_state_t enum (codes per REQ-014) SHALL live in the shared package tron_pkg, together with FRAMES_PER_SEC=60; the score and render blocks SHALL import it.
REQ-036 One sub-module SHALL be instantiated: edge_sync (2-flop synchronizer plus rising-edge pulse), used once each for frame_clk, start_key and pause_key.
REQ-037 The next-state logic SHALL be one always_comb block and the state register one always_ff block; the counter SHALL be a separate always_ff.

Verification
REQ-038 Bench SHALL cover: Reset, then start press -> round_reset pulse for 1 cycle, Game_State=1, countdown_sec=3; after 180 frame ticks -> Game_State=2, freeze=0.
REQ-039 Bench SHALL cover: in PLAY, reset_round pulse -> Game_State=1 next cycle, one round_reset pulse, countdown restarts at 3.
REQ-040 Bench SHALL cover: in PLAY, Blue_W and Red_W rise in the same cycle -> Game_State=5; start press at frame 100 ignored; start press at frame 301 -> Game_State=0.
REQ-041 Bench SHALL cover: in PLAY, pause press -> Game_State=6, freeze=1; Red_W=1 while paused -> no change; second pause press -> Game_State=2, then Game_State=4 on the next cycle.
REQ-042 Bench SHALL cover: start_key held high across Reset release -> Game_State stays 0; release and press again -> Game_State=1.
REQ-043 Bench SHALL cover: Reset asserted at COUNTDOWN frame 90 -> Game_State=0, countdown_sec=0 next cycle.
